gmii_pixel_unpack: RTL and testbench

//  Receive-side parser between the GMII RX pins and the pixel FIFO, in the clk125m domain.
//  - Strips preamble/SFD and the Ethernet header.
//  - Validates the per-packet X/Y header.
//  - Packs the payload into 29-bit words {x[1:0], y[10:0], pix[15:0]} on a FIFO write strobe.
//  - One packet carries half a video line: 640 pixels of 16 bits each.
//  - The downstream frame checker and FIFO consume fifo_wr_en/dout directly.

---
 rtl/gmii_pixel_unpack_if.sv | 24 ++
 rtl/gmii_pixel_unpack.sv | 171 +++++++++++++++++
 tb/tb_gmii_pixel_unpack.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_pixel_unpack_if.sv
// GMII receive pins, pixel FIFO write port and status for gmii_pixel_unpack.
// fifo_wr_en is a one-cycle valid with no ready: a word formed while fifo_full is high is discarded.
interface gmii_pixel_unpack_if;
   logic [7:0]  rxd;
   logic        rx_dv;
   logic        rx_er;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [28:0] dout;
   logic [15:0] pkt_ok;
   logic [15:0] pkt_drop;
   logic        overflow;
   logic [2:0]  dbg_state;

   modport master (
      output rxd, rx_dv, rx_er, fifo_full,
      input  fifo_wr_en, dout, pkt_ok, pkt_drop, overflow, dbg_state
   );

   modport slave (
      input  rxd, rx_dv, rx_er, fifo_full,
      output fifo_wr_en, dout, pkt_ok, pkt_drop, overflow, dbg_state
   );
endinterface

// File: rtl/gmii_pixel_unpack.sv
// GMII RX parser: strips preamble/Ethernet header, checks the X/Y header and
// packs 16-bit pixels into {x, y, pix} FIFO words, one every two bytes.
module gmii_pixel_unpack #(
   parameter logic [15:0] ETHERTYPE = 16'h3300,
   parameter int          PIX_WORDS = 640,
   parameter int          Y_MAX     = 719
) (
   input  logic                 clk125m,
   input  logic                 reset,
   gmii_pixel_unpack_if.slave   io_bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_ETH_HDR, S_XY_HDR, S_DATA, S_FCS, S_DROP
   } state_t;

   localparam logic [9:0]  LAST_WORD = 10'(PIX_WORDS - 1);
   localparam logic [10:0] Y_LIM     = 11'(Y_MAX);

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_rxd;
   logic        r_dv, r_er, r_full;
   logic [9:0]  r_cnt, w_cnt_nxt;
   logic        r_phase;
   logic [7:0]  r_et_hi, r_hi;
   logic [1:0]  r_x;
   logic [10:0] r_y;
   logic        r_wr_en;
   logic [28:0] r_dout;
   logic [15:0] r_pkt_ok, r_pkt_drop;
   logic        r_overflow;

   logic        w_ld_et_hi, w_ld_x, w_ld_yhi, w_ld_ylo, w_ld_hi;
   logic        w_word, w_inc_ok, w_inc_drop;
   logic [10:0] w_y;

   assign w_y = {r_y[10:8], r_rxd};

   always_ff @(posedge clk125m) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Priority outside IDLE: rx_dv low, then rx_er, then the byte itself.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ld_et_hi  = 1'b0;
      w_ld_x      = 1'b0;
      w_ld_yhi    = 1'b0;
      w_ld_ylo    = 1'b0;
      w_ld_hi     = 1'b0;
      w_word      = 1'b0;
      w_inc_ok    = 1'b0;
      w_inc_drop  = 1'b0;
      if (r_state == S_IDLE) begin
         if (r_dv) begin
            if (r_rxd == 8'h55) begin
               w_state_nxt = S_PREAMBLE;
               w_cnt_nxt   = 10'd1;
            end else if (r_rxd == 8'hD5) begin
               w_state_nxt = S_ETH_HDR;
               w_cnt_nxt   = 10'd0;
            end else begin
               w_state_nxt = S_DROP;
            end
         end
      end else if (!r_dv) begin
         w_state_nxt = S_IDLE;
         if (r_state == S_FCS && !r_er) w_inc_ok   = 1'b1;
         else                           w_inc_drop = 1'b1;
      end else if (r_er) begin
         w_state_nxt = S_DROP;
      end else begin
         case (r_state)
            S_PREAMBLE: begin
               if (r_rxd == 8'h55) begin
                  if (r_cnt == 10'd7) w_state_nxt = S_DROP;
                  else                w_cnt_nxt   = r_cnt + 10'd1;
               end else if (r_rxd == 8'hD5) begin
                  w_state_nxt = S_ETH_HDR;
                  w_cnt_nxt   = 10'd0;
               end else begin
                  w_state_nxt = S_DROP;
               end
            end
            S_ETH_HDR: begin
               w_cnt_nxt = r_cnt + 10'd1;
               if (r_cnt == 10'd12) w_ld_et_hi = 1'b1;
               if (r_cnt == 10'd13) begin
                  w_cnt_nxt = 10'd0;
                  if ({r_et_hi, r_rxd} == ETHERTYPE) w_state_nxt = S_XY_HDR;
                  else                               w_state_nxt = S_DROP;
               end
            end
            S_XY_HDR: begin
               w_cnt_nxt = r_cnt + 10'd1;
               case (r_cnt)
                  10'd0:   w_ld_x   = 1'b1;
                  10'd1:   w_ld_yhi = 1'b1;
                  default: begin
                     w_ld_ylo  = 1'b1;
                     w_cnt_nxt = 10'd0;
                     if (r_x > 2'd1 || w_y > Y_LIM) w_state_nxt = S_DROP;
                     else                           w_state_nxt = S_DATA;
                  end
               endcase
            end
            S_DATA: begin
               if (!r_phase) begin
                  w_ld_hi = 1'b1;
               end else begin
                  w_word    = 1'b1;
                  w_cnt_nxt = r_cnt + 10'd1;
                  if (r_cnt == LAST_WORD) begin
                     w_state_nxt = S_FCS;
                     w_cnt_nxt   = 10'd0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // r_phase follows w_ld_hi, so a half word is dropped whenever DATA is left.
   always_ff @(posedge clk125m) begin
      if (reset) begin
         r_rxd      <= 8'd0;
         r_dv       <= 1'b0;
         r_er       <= 1'b0;
         r_full     <= 1'b0;
         r_cnt      <= 10'd0;
         r_phase    <= 1'b0;
         r_et_hi    <= 8'd0;
         r_hi       <= 8'd0;
         r_x        <= 2'd0;
         r_y        <= 11'd0;
         r_wr_en    <= 1'b0;
         r_dout     <= 29'd0;
         r_pkt_ok   <= 16'd0;
         r_pkt_drop <= 16'd0;
         r_overflow <= 1'b0;
      end else begin
         r_rxd   <= io_bus.rxd;
         r_dv    <= io_bus.rx_dv;
         r_er    <= io_bus.rx_er;
         r_full  <= io_bus.fifo_full;
         r_cnt   <= w_cnt_nxt;
         r_phase <= w_ld_hi;
         if (w_ld_et_hi) r_et_hi    <= r_rxd;
         if (w_ld_x)     r_x        <= r_rxd[1:0];
         if (w_ld_yhi)   r_y[10:8]  <= r_rxd[2:0];
         if (w_ld_ylo)   r_y[7:0]   <= r_rxd;
         if (w_ld_hi)    r_hi       <= r_rxd;
         r_wr_en <= w_word && !r_full;
         if (w_word && !r_full) r_dout     <= {r_x, r_y, r_hi, r_rxd};
         if (w_word && r_full)  r_overflow <= 1'b1;
         if (w_inc_ok)   r_pkt_ok   <= r_pkt_ok + 16'd1;
         if (w_inc_drop) r_pkt_drop <= r_pkt_drop + 16'd1;
      end
   end

   assign io_bus.fifo_wr_en = r_wr_en;
   assign io_bus.dout       = r_dout;
   assign io_bus.pkt_ok     = r_pkt_ok;
   assign io_bus.pkt_drop   = r_pkt_drop;
   assign io_bus.overflow   = r_overflow;
   assign io_bus.dbg_state  = r_state;

endmodule

// File: tb/tb_gmii_pixel_unpack.sv
// Bench for gmii_pixel_unpack: packet driver with a scoreboard of expected
// words and strobe cycles, plus per-scenario counter checks.
module tb_gmii_pixel_unpack;

   logic clk125m;
   logic reset;
   int   cyc;
   int   checks;
   int   errors;
   int   strobes;

   logic [28:0] exp_q[$];
   int          exp_t_q[$];
   logic [28:0] mon_exp;
   int          mon_t;

   gmii_pixel_unpack_if bus ();

   gmii_pixel_unpack dut (
      .clk125m (clk125m),
      .reset   (reset),
      .io_bus  (bus)
   );

   initial begin
      clk125m = 1'b0;
      forever #4 clk125m = ~clk125m;
   end

   always @(posedge clk125m) cyc <= cyc + 1;

   // Scoreboard: every strobe must match the oldest expected word and cycle.
   always @(negedge clk125m) begin
      if (bus.fifo_wr_en === 1'b1) begin
         strobes++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe dout=%h cycle=%0d, expected no strobe", bus.dout, cyc);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_t   = exp_t_q.pop_front();
            if (bus.dout !== mon_exp || cyc !== mon_t) begin
               errors++;
               $display("FAIL dout_word got %h at cycle %0d, expected %h at cycle %0d", bus.dout, cyc, mon_exp, mon_t);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk125m);
      #1;
   endtask

   task automatic drive(input logic [7:0] d, input logic er);
      bus.rxd   = d;
      bus.rx_dv = 1'b1;
      bus.rx_er = er;
      tick();
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.rxd       = 8'd0;
      bus.rx_dv     = 1'b0;
      bus.rx_er     = 1'b0;
      bus.fifo_full = 1'b0;
      exp_q.delete();
      exp_t_q.delete();
      repeat (3) tick();
      reset = 1'b0;
      tick();
   endtask

   // er_word/full_lo..full_hi/rst_word < 0 disables that feature.
   task automatic send_pkt(input logic [7:0] sfd, input logic [15:0] et, input logic [7:0] xb,
                           input logic [10:0] y, input logic [15:0] pix_base, input int er_word,
                           input int full_lo, input int full_hi, input int rst_word, input bit good);
      logic [15:0] pix;
      logic        full;
      for (int i = 0; i < 7; i++) drive(8'h55, 1'b0);
      drive(sfd, 1'b0);
      for (int i = 0; i < 12; i++) drive(8'($urandom_range(0, 255)), 1'b0);
      drive(et[15:8], 1'b0);
      drive(et[7:0], 1'b0);
      drive(xb, 1'b0);
      drive({5'd0, y[10:8]}, 1'b0);
      drive(y[7:0], 1'b0);
      for (int w = 0; w < 640; w++) begin
         pix = pix_base + 16'(w);
         if (w == rst_word) begin
            void'(exp_q.pop_back());
            void'(exp_t_q.pop_back());
            reset         = 1'b1;
            bus.rx_dv     = 1'b0;
            bus.rx_er     = 1'b0;
            bus.fifo_full = 1'b0;
            tick();
            tick();
            reset = 1'b0;
            return;
         end
         full          = (w >= full_lo && w <= full_hi);
         bus.fifo_full = full;
         drive(pix[15:8], (w == er_word));
         bus.rxd   = pix[7:0];
         bus.rx_er = 1'b0;
         if (good && !full && !(er_word >= 0 && w >= er_word)) begin
            exp_q.push_back({xb[1:0], y, pix});
            exp_t_q.push_back(cyc + 2);
         end
         tick();
      end
      bus.fifo_full = 1'b0;
      for (int i = 0; i < 4; i++) drive(8'($urandom_range(0, 255)), 1'b0);
      bus.rx_dv = 1'b0;
      bus.rxd   = 8'd0;
      repeat (12) tick();
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.rxd   = 8'h55;
      bus.rx_dv = 1'b1;
      bus.rx_er = 1'b0;
      bus.fifo_full = 1'b0;
      repeat (3) tick();
      checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b expected 0", bus.fifo_wr_en); end
      checks++; if (bus.dout !== 29'd0) begin errors++; $display("FAIL rst_dout got %h expected 0", bus.dout); end
      checks++; if (bus.pkt_ok !== 16'd0) begin errors++; $display("FAIL rst_pkt_ok got %0d expected 0", bus.pkt_ok); end
      checks++; if (bus.pkt_drop !== 16'd0) begin errors++; $display("FAIL rst_pkt_drop got %0d expected 0", bus.pkt_drop); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b expected 0", bus.overflow); end
      checks++; if (bus.dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d expected 0", bus.dbg_state); end
      do_reset();
   endtask

   task automatic test_good_packet();
      int s0;
      do_reset();
      s0 = strobes;
      send_pkt(8'hD5, 16'h3300, 8'h00, 11'd5, 16'h0000, -1, -1, -2, -1, 1'b1);
      checks++; if (strobes - s0 !== 640) begin errors++; $display("FAIL good_strobes got %0d expected 640", strobes - s0); end
      checks++; if (bus.dout !== {2'd0, 11'd5, 16'h027F}) begin errors++; $display("FAIL good_last_dout got %h expected %h", bus.dout, {2'd0, 11'd5, 16'h027F}); end
      checks++; if (bus.pkt_ok !== 16'd1) begin errors++; $display("FAIL good_pkt_ok got %0d expected 1", bus.pkt_ok); end
      checks++; if (bus.pkt_drop !== 16'd0) begin errors++; $display("FAIL good_pkt_drop got %0d expected 0", bus.pkt_drop); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL good_drained got %0d left expected 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int s0;
      do_reset();
      s0 = strobes;
      send_pkt(8'hD5, 16'h3300, 8'hFD, 11'd719, 16'($urandom_range(0, 65535)), -1, -1, -2, -1, 1'b1);
      send_pkt(8'hD5, 16'h3300, 8'h00, 11'd0, 16'($urandom_range(0, 65535)), -1, -1, -2, -1, 1'b1);
      checks++; if (strobes - s0 !== 1280) begin errors++; $display("FAIL b2b_strobes got %0d expected 1280", strobes - s0); end
      checks++; if (bus.pkt_ok !== 16'd2) begin errors++; $display("FAIL b2b_pkt_ok got %0d expected 2", bus.pkt_ok); end
      checks++; if (bus.pkt_drop !== 16'd0) begin errors++; $display("FAIL b2b_pkt_drop got %0d expected 0", bus.pkt_drop); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_drained got %0d left expected 0", exp_q.size()); end
   endtask

   task automatic test_bad_eth();
      int s0;
      do_reset();
      s0 = strobes;
      send_pkt(8'hD5, 16'h0800, 8'h00, 11'd5, 16'h1234, -1, -1, -2, -1, 1'b0);
      checks++; if (bus.pkt_drop !== 16'd1) begin errors++; $display("FAIL ethtype_pkt_drop got %0d expected 1", bus.pkt_drop); end
      send_pkt(8'h5D, 16'h3300, 8'h00, 11'd5, 16'h1234, -1, -1, -2, -1, 1'b0);
      checks++; if (bus.pkt_drop !== 16'd2) begin errors++; $display("FAIL sfd_pkt_drop got %0d expected 2", bus.pkt_drop); end
      checks++; if (strobes - s0 !== 0) begin errors++; $display("FAIL bad_eth_strobes got %0d expected 0", strobes - s0); end
      checks++; if (bus.pkt_ok !== 16'd0) begin errors++; $display("FAIL bad_eth_pkt_ok got %0d expected 0", bus.pkt_ok); end
   endtask

   task automatic test_bad_xy();
      int s0;
      do_reset();
      s0 = strobes;
      send_pkt(8'hD5, 16'h3300, 8'h00, 11'd720, 16'h0100, -1, -1, -2, -1, 1'b0);
      checks++; if (bus.pkt_drop !== 16'd1) begin errors++; $display("FAIL y720_pkt_drop got %0d expected 1", bus.pkt_drop); end
      send_pkt(8'hD5, 16'h3300, 8'h02, 11'd100, 16'h0100, -1, -1, -2, -1, 1'b0);
      checks++; if (bus.pkt_drop !== 16'd2) begin errors++; $display("FAIL x2_pkt_drop got %0d expected 2", bus.pkt_drop); end
      checks++; if (strobes - s0 !== 0) begin errors++; $display("FAIL bad_xy_strobes got %0d expected 0", strobes - s0); end
      checks++; if (bus.pkt_ok !== 16'd0) begin errors++; $display("FAIL bad_xy_pkt_ok got %0d expected 0", bus.pkt_ok); end
   endtask

   task automatic test_rx_er();
      int s0;
      do_reset();
      s0 = strobes;
      send_pkt(8'hD5, 16'h3300, 8'h01, 11'd300, 16'h4000, 100, -1, -2, -1, 1'b1);
      checks++; if (strobes - s0 !== 100) begin errors++; $display("FAIL er_strobes got %0d expected 100", strobes - s0); end
      checks++; if (bus.pkt_drop !== 16'd1) begin errors++; $display("FAIL er_pkt_drop got %0d expected 1", bus.pkt_drop); end
      checks++; if (bus.pkt_ok !== 16'd0) begin errors++; $display("FAIL er_pkt_ok got %0d expected 0", bus.pkt_ok); end
      s0 = strobes;
      send_pkt(8'hD5, 16'h3300, 8'h00, 11'd301, 16'h5000, -1, -1, -2, -1, 1'b1);
      checks++; if (strobes - s0 !== 640) begin errors++; $display("FAIL er_next_strobes got %0d expected 640", strobes - s0); end
      checks++; if (bus.pkt_ok !== 16'd1) begin errors++; $display("FAIL er_next_pkt_ok got %0d expected 1", bus.pkt_ok); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL er_drained got %0d left expected 0", exp_q.size()); end
   endtask

   task automatic test_fifo_full();
      int s0;
      do_reset();
      s0 = strobes;
      send_pkt(8'hD5, 16'h3300, 8'h01, 11'd42, 16'h8000, -1, 10, 19, -1, 1'b1);
      checks++; if (strobes - s0 !== 630) begin errors++; $display("FAIL full_strobes got %0d expected 630", strobes - s0); end
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL full_overflow got %b expected 1", bus.overflow); end
      checks++; if (bus.pkt_ok !== 16'd1) begin errors++; $display("FAIL full_pkt_ok got %0d expected 1", bus.pkt_ok); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL full_drained got %0d left expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_data();
      int s0;
      do_reset();
      send_pkt(8'hD5, 16'h3300, 8'h01, 11'd7, 16'hC000, -1, -1, -2, 50, 1'b1);
      checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr_en got %b expected 0", bus.fifo_wr_en); end
      checks++; if (bus.dout !== 29'd0) begin errors++; $display("FAIL midrst_dout got %h expected 0", bus.dout); end
      checks++; if (bus.dbg_state !== 3'd0) begin errors++; $display("FAIL midrst_state got %0d expected 0", bus.dbg_state); end
      checks++; if (bus.pkt_drop !== 16'd0) begin errors++; $display("FAIL midrst_pkt_drop got %0d expected 0", bus.pkt_drop); end
      repeat (4) tick();
      s0 = strobes;
      send_pkt(8'hD5, 16'h3300, 8'h00, 11'd8, 16'hD000, -1, -1, -2, -1, 1'b1);
      checks++; if (strobes - s0 !== 640) begin errors++; $display("FAIL midrst_next_strobes got %0d expected 640", strobes - s0); end
      checks++; if (bus.pkt_ok !== 16'd1) begin errors++; $display("FAIL midrst_next_pkt_ok got %0d expected 1", bus.pkt_ok); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL midrst_drained got %0d left expected 0", exp_q.size()); end
   endtask

   initial begin
      cyc     = 0;
      checks  = 0;
      errors  = 0;
      strobes = 0;
      test_reset();
      test_good_packet();
      test_back_to_back();
      test_bad_eth();
      test_bad_xy();
      test_rx_er();
      test_fifo_full();
      test_reset_mid_data();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
